// File: rtl/adder_pkg.sv
// Shared constants and types for the AMBA-attached adder: bus widths,
// register indices and the common data word type.
package adder_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned NUM_REGS = 3;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Word indices, compared against the full addr_in width.
    localparam addr_t REG_R0 = addr_t'(0);
    localparam addr_t REG_R1 = addr_t'(1);
    localparam addr_t REG_R2 = addr_t'(2);

endpackage

// File: rtl/reg_file.sv
// Three-entry operand/result register file with a single read/write port
// and continuous parallel export of every register.
module reg_file
    import adder_pkg::*;
(
    input  logic              ACLK,
    input  logic              ARSTn,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rw,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] r0,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2
);

    word_t regs [NUM_REGS];

    // Access protocol: no strobe, every edge is one access chosen by rw.
    // Writes leave data_out untouched; reads never touch the registers.
    // Out-of-range addresses drop writes and read back zero.
    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            data_out <= '0;
        end else if (rw) begin
            case (addr_in)
                REG_R0:  regs[0] <= data_in;
                REG_R1:  regs[1] <= data_in;
                REG_R2:  regs[2] <= data_in;
                default: ;
            endcase
        end else begin
            case (addr_in)
                REG_R0:  data_out <= regs[0];
                REG_R1:  data_out <= regs[1];
                REG_R2:  data_out <= regs[2];
                default: data_out <= '0;
            endcase
        end
    end

    assign r0 = regs[0];
    assign r1 = regs[1];
    assign r2 = regs[2];

endmodule

// File: tb/tb_reg_file.sv
// Randomized scoreboard bench for reg_file: the driver pushes expected
// outputs from an array model, a monitor pops and compares after each edge.
module tb_reg_file;

    logic        ACLK;
    logic        ARSTn;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic        rw;
    logic [31:0] data_out;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] r2;

    reg_file dut (
        .ACLK     (ACLK),
        .ARSTn    (ARSTn),
        .addr_in  (addr_in),
        .data_in  (data_in),
        .rw       (rw),
        .data_out (data_out),
        .r0       (r0),
        .r1       (r1),
        .r2       (r2)
    );

    // clock / reset
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // reference model and scoreboard
    logic [31:0]  m_regs [3];
    logic [31:0]  m_dout;
    logic [127:0] exp_q [$];
    string        tag_q [$];
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [127:0] e);
        check({tag, ".data_out"}, data_out, e[127:96]);
        check({tag, ".r0"}, r0, e[95:64]);
        check({tag, ".r1"}, r1, e[63:32]);
        check({tag, ".r2"}, r2, e[31:0]);
    endtask

    // driver: one access per edge; the model applies the access rules directly
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input string tag);
        int idx;
        @(negedge ACLK);
        rw      = w;
        addr_in = a;
        data_in = d;
        idx     = (a < 32'd3) ? int'(a) : -1;
        if (w) begin
            if (idx >= 0) m_regs[idx] = d;
        end else begin
            m_dout = (idx >= 0) ? m_regs[idx] : 32'h0;
        end
        exp_q.push_back({m_dout, m_regs[0], m_regs[1], m_regs[2]});
        tag_q.push_back(tag);
    endtask

    // monitor
    initial begin
        logic [127:0] e;
        string        t;
        forever begin
            @(posedge ACLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check_all(t, e);
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_regs[i] = 32'h0;
        m_dout = 32'h0;
    endtask

    initial begin
        logic [31:0] a;
        int          budget;
        model_reset();
        ARSTn   = 1'b1;
        rw      = 1'b0;
        addr_in = 32'h0;
        data_in = 32'h0;

        // asynchronous reset between edges
        #7 ARSTn = 1'b0;
        #1 check_all("reset_async", 128'h0);
        @(negedge ACLK);
        ARSTn = 1'b1;
        repeat (3) access(1'b0, 32'h0, 32'h0, "idle");

        access(1'b1, 32'd1, 32'hDEADBEEF, "single_write");

        access(1'b1, 32'd0, 32'h1, "wr_r0");
        access(1'b1, 32'd1, 32'h2, "wr_r1");
        access(1'b1, 32'd2, 32'hFFFF_FFFF, "wr_r2");
        access(1'b0, 32'd0, 32'h0, "rd_r0");
        access(1'b0, 32'd1, 32'h0, "rd_r1");
        access(1'b0, 32'd2, 32'h0, "rd_r2");

        access(1'b1, 32'd3, 32'h1234, "oor_write");
        access(1'b0, 32'h8000_0002, 32'h0, "oor_read");

        access(1'b1, 32'd2, 32'hA5A5_A5A5, "wr_then_rd_w");
        access(1'b0, 32'd2, 32'h0, "wr_then_rd_r");

        // reset in the middle of a pending write
        access(1'b1, 32'd1, 32'hDEADBEEF, "load_r1");
        @(posedge ACLK);
        #2;
        @(negedge ACLK);
        rw      = 1'b1;
        addr_in = 32'd0;
        data_in = 32'h55;
        #2 ARSTn = 1'b0;
        #1 check_all("reset_midop", 128'h0);
        @(posedge ACLK);
        #1 check("reset_midop_edge.r0", r0, 32'h0);
        @(negedge ACLK);
        ARSTn = 1'b1;
        model_reset();
        rw = 1'b0;
        addr_in = 32'h0;
        access(1'b0, 32'd1, 32'h0, "post_reset_rd");

        // randomized traffic, mostly in range with occasional wide addresses
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 3));
            access(1'($urandom_range(0, 1)), a, $urandom, "random");
        end

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge ACLK);
            budget--;
        end
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
